// File: rtl/speaker_i2s.sv
// Square-wave tone generator for two channels feeding a 16-bit I2S DAC.
// All DAC clocks come straight from divider register bits; samples are snapshotted once per frame.
module speaker_i2s #(
    parameter int          CLK_HZ = 100000000,
    parameter int          MAX_HZ = 20000,
    parameter logic [15:0] VOLUME = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] freqL,
    input  logic [25:0] freqR,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin,
    output logic        frame_start
);

    localparam logic [26:0] HALF_W  = 27'(CLK_HZ / 2);
    localparam logic [25:0] MAX_W   = 26'(MAX_HZ);
    localparam logic [15:0] NEG_VOL = (~VOLUME) + 16'd1;

    logic [8:0]  div_cnt_q, div_cnt_d;
    logic [26:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic        sq_l_q, sq_l_d, sq_r_q, sq_r_d;
    logic [30:0] sreg_q, sreg_d;
    logic        sdin_q, sdin_d;
    logic        fs_q, fs_d;

    logic        silent_l_s, silent_r_s;
    logic [27:0] step_l_s, step_r_s;
    logic [15:0] sample_l_s, sample_r_s;

    function automatic logic is_silent(input logic [25:0] freq);
        is_silent = (freq == 26'd0) || (freq > MAX_W);
    endfunction

    // Returns {wrapped, next accumulator}; wrapped marks a half-period boundary.
    function automatic logic [27:0] acc_step(input logic [26:0] acc, input logic [25:0] freq);
        logic [26:0] sum;
        sum = acc + {1'b0, freq};
        if (sum >= HALF_W) begin
            acc_step = {1'b1, sum - HALF_W};
        end else begin
            acc_step = {1'b0, sum};
        end
    endfunction

    function automatic logic [15:0] sample_of(input logic silent, input logic sq);
        if (silent) begin
            sample_of = 16'd0;
        end else if (sq) begin
            sample_of = VOLUME;
        end else begin
            sample_of = NEG_VOL;
        end
    endfunction

    // Next-state logic for divider, both tone channels, serializer and frame pulse.
    always_comb begin
        div_cnt_d  = div_cnt_q + 9'd1;
        silent_l_s = is_silent(freqL);
        silent_r_s = is_silent(freqR);
        step_l_s   = acc_step(acc_l_q, freqL);
        step_r_s   = acc_step(acc_r_q, freqR);
        sample_l_s = sample_of(silent_l_s, sq_l_q);
        sample_r_s = sample_of(silent_r_s, sq_r_q);
        acc_l_d    = acc_l_q;
        sq_l_d     = sq_l_q;
        acc_r_d    = acc_r_q;
        sq_r_d     = sq_r_q;
        sreg_d     = sreg_q;
        sdin_d     = sdin_q;

        if (silent_l_s) begin
            acc_l_d = 27'd0;
            sq_l_d  = 1'b0;
        end else begin
            acc_l_d = step_l_s[26:0];
            sq_l_d  = sq_l_q ^ step_l_s[27];
        end

        if (silent_r_s) begin
            acc_r_d = 27'd0;
            sq_r_d  = 1'b0;
        end else begin
            acc_r_d = step_r_s[26:0];
            sq_r_d  = sq_r_q ^ step_r_s[27];
        end

        // Data moves only on SCK falling edges; the frame load uses pre-toggle sq.
        if (div_cnt_q == 9'd15) begin
            sdin_d = sample_l_s[15];
            sreg_d = {sample_l_s[14:0], sample_r_s};
        end else if (div_cnt_q[3:0] == 4'hF) begin
            sdin_d = sreg_q[30];
            sreg_d = {sreg_q[29:0], 1'b0};
        end else begin
            sdin_d = sdin_q;
            sreg_d = sreg_q;
        end

        fs_d = (div_cnt_d == 9'd15);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= 9'd0;
            acc_l_q   <= 27'd0;
            acc_r_q   <= 27'd0;
            sq_l_q    <= 1'b0;
            sq_r_q    <= 1'b0;
            sreg_q    <= 31'd0;
            sdin_q    <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            sq_l_q    <= sq_l_d;
            sq_r_q    <= sq_r_d;
            sreg_q    <= sreg_d;
            sdin_q    <= sdin_d;
            fs_q      <= fs_d;
        end
    end

    assign audio_mclk  = div_cnt_q[1];
    assign audio_sck   = div_cnt_q[3];
    assign audio_lrck  = div_cnt_q[8];
    assign audio_sdin  = sdin_q;
    assign frame_start = fs_q;

endmodule

// File: doc/speaker_i2s.md
# speaker_i2s

Back-end audio driver: converts the per-channel tone frequencies from the game sound mux into square-wave PCM samples and serializes them onto the Pmod I2S DAC pins. It sits between the game sound mux (freqL/freqR producer) and the board audio pins. The value 50000000 issued by the mux when muted or idle is interpreted here as silence.

## Interface
- CLK_HZ, 100000000: system clock frequency; HALF = CLK_HZ/2 is the phase-accumulator wrap value.
- MAX_HZ, 20000: highest audible tone; any freq above this, or 0, is silence.
- VOLUME, 16'h1000: square-wave amplitude; samples are +VOLUME / -VOLUME, two's complement.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- freqL  in  26  left tone frequency in Hz.
- freqR  in  26  right tone frequency in Hz.
- audio_mclk  out  1  DAC master clock, clk/4.
- audio_sck  out  1  serial bit clock, clk/16.
- audio_lrck  out  1  word select, clk/512; 0 = left, 1 = right.
- audio_sdin  out  1  serial data, I2S format, MSB first.
- frame_start  out  1  one-cycle pulse when a new L/R sample pair is latched.

## Operation
- Free-running 9-bit div_cnt, +1 per clk, wraps 511→0. audio_mclk = div_cnt[1], audio_sck = div_cnt[3], audio_lrck = div_cnt[8]; all three are direct register bits, glitch-free.
- Per channel, 27-bit accumulator acc and square-state bit sq:
  - silent (freq == 0 or freq > MAX_HZ): acc ← 0, sq ← 0, sample = 0.
  - else if acc + freq ≥ HALF: acc ← acc + freq − HALF, sq ← ~sq.
  - else acc ← acc + freq.
  - sample = sq ? +VOLUME : −VOLUME. Period is exactly CLK_HZ/freq clocks when freq divides HALF.
- A frequency change does not reset acc or sq (phase-continuous). A silent→audible transition starts from acc = 0, sq = 0.
- Serializer: 31-bit shift register sreg plus registered audio_sdin. Updates occur only on clocks where div_cnt[3:0] == 15, i.e. coincident with the falling edge of audio_sck.
  - div_cnt == 15 (load): audio_sdin ← sampleL[15]; sreg ← {sampleL[14:0], sampleR[15:0]}; frame_start = 1 on this clock.
  - Other div_cnt[3:0] == 15 clocks: audio_sdin ← sreg[30]; sreg ← sreg << 1.
  - Result: in SCK period k of a frame (k = div_cnt[8:4]), k = 1..16 carries L[15..0], k = 17..31 carries R[15..1], and k = 0 of the next frame carries R[0]. This gives standard I2S one-bit delay after each LRCK edge.
- Samples are snapshotted only at the load clock. Mid-frame freq or sq changes affect the next frame only.

## Timing
- Reset (rst = 0): div_cnt, acc, sq, sreg, audio_sdin = 0; therefore audio_mclk = audio_sck = audio_lrck = 0 and frame_start = 0. Asynchronous reset is effective mid-frame; after release, counting restarts at div_cnt = 0.
- First frame_start occurs 16 clocks after reset release (div_cnt 0→15), and every 512 clocks thereafter.
- Latency from freq input to accumulator: 1 clk. Latency from freq input to audio_sdin: at most one frame plus 16 clk.
- audio_sdin is stable for 16 clk around each audio_sck rising edge (changes at div_cnt[3:0] 15→0; sck rises at 7→8).
- If the sq toggle and the load clock coincide, the load uses the pre-toggle sq.

## Test plan
- Reset: hold rst low for 20 clk mid-run → all outputs 0. Release → frame_start first pulses at clock 16, then again at clock 528.
- Silence: freqL = freqR = 50000000 → audio_sdin constantly 0 for 4 frames. Repeat with freqL = 0 and freqL = 20001; both must also be silent.
- Tone: freqL = 1000, freqR = 50000000 → left sq toggles every 50000 clk. Decoded left words alternate 16'h1000 / 16'hF000 (−4096); decoded right words are all 0.
- Bit alignment: force sampleL = 16'h1000, sampleR = 16'hF000 → sampled on audio_sck rising edges, the left half-frame reads 0,0001000000000000,… and the right half-frame reads L-LSB first, then 111100000000000. The R LSB appears in k = 0 of the next frame.
- Phase continuity: freqR = 440, then switch to 880 mid-period → no reset of sq. The next toggle occurs when acc crosses 50000000 using the new increment (check against a reference model).
- Reset mid-frame at div_cnt = 300 with both tones active → outputs go to 0 immediately. After release, sq starts at 0 and the first loaded samples are −VOLUME (16'hF000).
